// File: rtl/rs_dispatch_unit.sv
// rtl/rs_dispatch_unit.sv - dispatch buffer between rename and the reservation station write port
// Build option STALL_CNT_EN adds a saturating counter of cycles where the buffer holds entries but sends none.
module rs_dispatch_unit #(
  parameter int WIDTH = 35,
  parameter int RS2_W = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              ren_valid_1,
  input  logic              ren_valid_2,
  input  logic [52:0]       ren_must_1,
  input  logic [52:0]       ren_must_2,
  input  logic [WIDTH-1:0]  ren_data_1,
  input  logic [WIDTH-1:0]  ren_data_2,
  output logic              ren_ready,
  input  logic              free_1,
  input  logic              free_2,
  input  logic              hit_wb_agu,
  input  logic [5:0]        rd_alu_wb,
  input  logic [5:0]        rd_sfu_wb,
  input  logic [5:0]        rd_agu_wb,
  input  logic [31:0]       result_alu_wb,
  input  logic [31:0]       result_sfu_wb,
  input  logic [31:0]       result_agu_wb,
  output logic              rs_write_dis,
  output logic              write_num_dis,
  output logic [52:0]       rs_must_1,
  output logic [52:0]       rs_must_2,
  output logic [WIDTH-1:0]  write_data_1,
  output logic [WIDTH-1:0]  write_data_2
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int MUST_W = 53;
  localparam int NSRC   = DEPTH + 2;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

  logic [MUST_W-1:0] must_q [DEPTH];
  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [PTR_W-1:0]  head, tail, head_p1, tail_p1;
  logic [PTR_W:0]    count, credit_w;
  logic [1:0]        credit, send_n, push_n;
  logic              accept;

  logic [MUST_W-1:0] src_must  [NSRC];
  logic [WIDTH-1:0]  src_data  [NSRC];
  logic [MUST_W-1:0] woke_must [NSRC];
  logic [WIDTH-1:0]  woke_data [NSRC];

  // Priority ALU > SFU > AGU; returns {hit, value}.
  function automatic logic [32:0] wb_match(
    input logic [5:0]  tag,
    input logic [5:0]  t_alu, t_sfu, t_agu,
    input logic        agu_hit,
    input logic [31:0] v_alu, v_sfu, v_agu
  );
    if (tag == t_alu) return {1'b1, v_alu};
    else if (tag == t_sfu) return {1'b1, v_sfu};
    else if (agu_hit && tag == t_agu) return {1'b1, v_agu};
    else return 33'd0;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src_must[i] = must_q[i];
      src_data[i] = data_q[i];
    end
    src_must[DEPTH]   = ren_must_1;
    src_data[DEPTH]   = ren_data_1;
    src_must[DEPTH+1] = ren_must_2;
    src_data[DEPTH+1] = ren_data_2;
  end

  // Buffered slots, outgoing slots and incoming rename slots all see the same broadcast.
  always_comb begin
    logic [32:0] m1, m2;
    for (int k = 0; k < NSRC; k++) begin
      woke_must[k] = src_must[k];
      woke_data[k] = src_data[k];
      m1 = wb_match(src_must[k][8:3], rd_alu_wb, rd_sfu_wb, rd_agu_wb, hit_wb_agu,
                    result_alu_wb, result_sfu_wb, result_agu_wb);
      m2 = wb_match(src_must[k][14:9], rd_alu_wb, rd_sfu_wb, rd_agu_wb, hit_wb_agu,
                    result_alu_wb, result_sfu_wb, result_agu_wb);
      if (!src_must[k][1] && m1[32]) begin
        woke_must[k][1]     = 1'b1;
        woke_must[k][52:21] = m1[31:0];
      end
      if (!src_must[k][2] && m2[32]) begin
        woke_must[k][2]           = 1'b1;
        woke_data[k][RS2_W-1:0]   = m2[RS2_W-1:0];
      end
    end
  end

  assign head_p1   = head + 1'b1;
  assign tail_p1   = tail + 1'b1;
  assign ren_ready = (DEPTH_C - count) >= TWO_C;
  assign accept    = ren_ready & ren_valid_1;
  assign push_n    = accept ? (ren_valid_2 ? 2'd2 : 2'd1) : 2'd0;

  always_comb begin
    credit   = free_2 ? 2'd2 : (free_1 ? 2'd1 : 2'd0);
    credit_w = (PTR_W+1)'(credit);
    send_n   = (count < credit_w) ? count[1:0] : credit;
    if (flush) send_n = 2'd0;
  end

  assign rs_write_dis  = send_n != 2'd0;
  assign write_num_dis = send_n == 2'd2;
  assign rs_must_1     = (count != '0)   ? woke_must[{1'b0, head}]    : '0;
  assign write_data_1  = (count != '0)   ? woke_data[{1'b0, head}]    : '0;
  assign rs_must_2     = (count >= TWO_C) ? woke_must[{1'b0, head_p1}] : '0;
  assign write_data_2  = (count >= TWO_C) ? woke_data[{1'b0, head_p1}] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        must_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        must_q[i] <= woke_must[i];
        data_q[i] <= woke_data[i];
      end
      if (accept) begin
        must_q[tail] <= woke_must[DEPTH];
        data_q[tail] <= woke_data[DEPTH];
        if (ren_valid_2) begin
          must_q[tail_p1] <= woke_must[DEPTH+1];
          data_q[tail_p1] <= woke_data[DEPTH+1];
        end
      end
      head  <= head + PTR_W'(send_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(send_n);
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt <= '0;
    else if (count != '0 && send_n == 2'd0 && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  // stall instrumentation not built
`endif

endmodule

// File: tb/tb_rs_dispatch_unit.sv
// tb/tb_rs_dispatch_unit.sv - self-checking bench for rs_dispatch_unit
module tb_rs_dispatch_unit;
  localparam int DEPTH = 4;

  typedef struct {
    logic [5:0]  rob, tag1, tag2;
    logic        rdy1, rdy2;
    logic [31:0] val1, val2;
    logic [2:0]  upper;
  } ent_t;

  typedef struct {
    logic v1, v2;
    logic [5:0] rob1, rob2;
    logic f1, f2;
    logic e_ready, e_wr, e_num;
    logic [5:0] e_rob1, e_rob2;
  } row_t;

  logic clk = 0, reset_n = 0, flush = 0;
  logic ren_valid_1 = 0, ren_valid_2 = 0;
  logic [52:0] ren_must_1, ren_must_2, rs_must_1, rs_must_2;
  logic [34:0] ren_data_1, ren_data_2, write_data_1, write_data_2;
  logic ren_ready, free_1 = 0, free_2 = 0, hit_wb_agu = 0;
  logic [5:0] rd_alu_wb = 0, rd_sfu_wb = 0, rd_agu_wb = 0;
  logic [31:0] result_alu_wb = 0, result_sfu_wb = 0, result_agu_wb = 0;
  logic rs_write_dis, write_num_dis;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ent_t in1, in2;
  ent_t mq[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic logic [52:0] pack_must(ent_t e);
    return {e.val1, e.rob, e.tag2, e.tag1, e.rdy2, e.rdy1, 1'b1};
  endfunction
  function automatic logic [34:0] pack_data(ent_t e);
    return {e.upper, e.val2};
  endfunction

  always_comb begin
    ren_must_1 = pack_must(in1);
    ren_must_2 = pack_must(in2);
    ren_data_1 = pack_data(in1);
    ren_data_2 = pack_data(in2);
  end

  rs_dispatch_unit dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .ren_valid_1(ren_valid_1), .ren_valid_2(ren_valid_2),
    .ren_must_1(ren_must_1), .ren_must_2(ren_must_2),
    .ren_data_1(ren_data_1), .ren_data_2(ren_data_2),
    .ren_ready(ren_ready), .free_1(free_1), .free_2(free_2),
    .hit_wb_agu(hit_wb_agu), .rd_alu_wb(rd_alu_wb), .rd_sfu_wb(rd_sfu_wb), .rd_agu_wb(rd_agu_wb),
    .result_alu_wb(result_alu_wb), .result_sfu_wb(result_sfu_wb), .result_agu_wb(result_agu_wb),
    .rs_write_dis(rs_write_dis), .write_num_dis(write_num_dis),
    .rs_must_1(rs_must_1), .rs_must_2(rs_must_2),
    .write_data_1(write_data_1), .write_data_2(write_data_2)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  function automatic ent_t mk(logic [5:0] rob, logic [5:0] t1, logic r1, logic [5:0] t2, logic r2);
    ent_t e;
    e.rob = rob; e.tag1 = t1; e.rdy1 = r1; e.tag2 = t2; e.rdy2 = r2;
    e.val1 = 32'h1000_0000 + 32'(rob); e.val2 = 32'h2000_0000 + 32'(rob); e.upper = rob[2:0];
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.rob = 6'($urandom); e.tag1 = 6'($urandom_range(0, 7)); e.tag2 = 6'($urandom_range(0, 7));
    e.rdy1 = 1'($urandom_range(0, 1)); e.rdy2 = 1'($urandom_range(0, 1));
    e.val1 = $urandom; e.val2 = $urandom; e.upper = 3'($urandom);
    return e;
  endfunction

  // Which broadcast (if any) supplies a tag this cycle: {hit, value}.
  function automatic logic [32:0] bcast(logic [5:0] tag);
    if (tag == rd_alu_wb) return {1'b1, result_alu_wb};
    if (tag == rd_sfu_wb) return {1'b1, result_sfu_wb};
    if (hit_wb_agu && tag == rd_agu_wb) return {1'b1, result_agu_wb};
    return 33'd0;
  endfunction

  function automatic ent_t wake(ent_t e);
    ent_t r = e;
    logic [32:0] b;
    if (!e.rdy1) begin
      b = bcast(e.tag1);
      if (b[32]) begin r.rdy1 = 1'b1; r.val1 = b[31:0]; end
    end
    if (!e.rdy2) begin
      b = bcast(e.tag2);
      if (b[32]) begin r.rdy2 = 1'b1; r.val2 = b[31:0]; end
    end
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    flush = 0; ren_valid_1 = 0; ren_valid_2 = 0; free_1 = 0; free_2 = 0;
    rd_alu_wb = 6'h3F; rd_sfu_wb = 6'h3E; rd_agu_wb = 6'h3D; hit_wb_agu = 0;
    result_alu_wb = 0; result_sfu_wb = 0; result_agu_wb = 0;
    in1 = mk(0, 0, 1, 0, 1); in2 = mk(0, 0, 1, 0, 1);
  endtask

  // Called at negedge: compare against the queue model, then advance it across the next posedge.
  task automatic model_cycle();
    int credit, n;
    logic exp_ready;
    ent_t w;
    exp_ready = (DEPTH - mq.size()) >= 2;
    credit = free_2 ? 2 : (free_1 ? 1 : 0);
    n = flush ? 0 : ((mq.size() < credit) ? mq.size() : credit);
    chk("ren_ready", 64'(ren_ready), 64'(exp_ready));
    chk("rs_write_dis", 64'(rs_write_dis), 64'(n >= 1));
    chk("write_num_dis", 64'(write_num_dis), 64'(n == 2));
    if (n >= 1) begin
      w = wake(mq[0]);
      chk("slot1_must", 64'(rs_must_1), 64'(pack_must(w)));
      chk("slot1_data", 64'(write_data_1), 64'(pack_data(w)));
    end
    if (n == 2) begin
      w = wake(mq[1]);
      chk("slot2_must", 64'(rs_must_2), 64'(pack_must(w)));
      chk("slot2_data", 64'(write_data_2), 64'(pack_data(w)));
    end
    if (flush) mq.delete();
    else begin
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      foreach (mq[i]) mq[i] = wake(mq[i]);
      if (exp_ready && ren_valid_1) begin
        mq.push_back(wake(in1));
        if (ren_valid_2) mq.push_back(wake(in2));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle();
    mq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ren_ready", 64'(ren_ready), 64'd1);
    chk("rst_write_dis", 64'(rs_write_dis), 64'd0);
    chk("rst_num_dis", 64'(write_num_dis), 64'd0);
    chk("rst_must1", 64'(rs_must_1), 64'd0);
    chk("rst_data1", 64'(write_data_1), 64'd0);
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  row_t tbl[10];

  initial begin
    //          v1 v2 rob1 rob2 f1 f2 rdy wr num erob1 erob2
    tbl[0] = '{1, 1,  5,   6,   0, 0, 1,  0, 0,  0,    0};
    tbl[1] = '{0, 0,  0,   0,   1, 1, 1,  1, 1,  5,    6};
    tbl[2] = '{1, 1,  7,   8,   0, 0, 1,  0, 0,  0,    0};
    tbl[3] = '{1, 1,  9,   10,  0, 0, 1,  0, 0,  0,    0};
    tbl[4] = '{0, 0,  0,   0,   0, 0, 0,  0, 0,  0,    0};
    tbl[5] = '{1, 0,  11,  0,   1, 0, 0,  1, 0,  7,    0};
    tbl[6] = '{0, 0,  0,   0,   1, 0, 0,  1, 0,  8,    0};
    tbl[7] = '{0, 0,  0,   0,   1, 0, 1,  1, 0,  9,    0};
    tbl[8] = '{0, 0,  0,   0,   1, 1, 1,  1, 0,  10,   0};
    tbl[9] = '{0, 0,  0,   0,   1, 1, 1,  0, 0,  0,    0};

    do_reset();

    for (int r = 0; r < 10; r++) begin
      idle();
      ren_valid_1 = tbl[r].v1; ren_valid_2 = tbl[r].v2;
      in1 = mk(tbl[r].rob1, 0, 1, 0, 1); in2 = mk(tbl[r].rob2, 0, 1, 0, 1);
      free_1 = tbl[r].f1; free_2 = tbl[r].f2;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), 64'(ren_ready), 64'(tbl[r].e_ready));
      chk($sformatf("tbl%0d_wr", r), 64'(rs_write_dis), 64'(tbl[r].e_wr));
      chk($sformatf("tbl%0d_num", r), 64'(write_num_dis), 64'(tbl[r].e_num));
      if (tbl[r].e_wr) chk($sformatf("tbl%0d_rob1", r), 64'(rs_must_1[20:15]), 64'(tbl[r].e_rob1));
      if (tbl[r].e_num) chk($sformatf("tbl%0d_rob2", r), 64'(rs_must_2[20:15]), 64'(tbl[r].e_rob2));
      model_cycle();
    end

    // SFU wakeup of an outgoing entry in its send cycle
    idle(); in1 = mk(20, 6'h12, 0, 0, 1); ren_valid_1 = 1;
    @(negedge clk); model_cycle();
    idle(); rd_sfu_wb = 6'h12; result_sfu_wb = 32'hDEAD_BEEF; free_1 = 1;
    @(negedge clk);
    chk("sfu_send_wr", 64'(rs_write_dis), 64'd1);
    chk("sfu_send_rdy", 64'(rs_must_1[1]), 64'd1);
    chk("sfu_send_val", 64'(rs_must_1[52:21]), 64'hDEAD_BEEF);
    model_cycle();

    // wakeup captured while buffered, sent later
    idle(); in1 = mk(21, 6'h13, 0, 0, 1); ren_valid_1 = 1;
    @(negedge clk); model_cycle();
    idle(); rd_sfu_wb = 6'h13; result_sfu_wb = 32'h1234_5678;
    @(negedge clk); model_cycle();
    idle(); free_1 = 1;
    @(negedge clk);
    chk("held_rdy", 64'(rs_must_1[1]), 64'd1);
    chk("held_val", 64'(rs_must_1[52:21]), 64'h1234_5678);
    model_cycle();

    // AGU without hit is ignored; ALU beats SFU
    idle(); in1 = mk(22, 6'h15, 0, 6'h16, 0); ren_valid_1 = 1;
    @(negedge clk); model_cycle();
    idle(); rd_agu_wb = 6'h15; result_agu_wb = 32'h7777_7777;
    rd_alu_wb = 6'h16; result_alu_wb = 32'hA5A5_A5A5;
    rd_sfu_wb = 6'h16; result_sfu_wb = 32'h5A5A_5A5A; free_1 = 1;
    @(negedge clk);
    chk("agu_nohit_rdy", 64'(rs_must_1[1]), 64'd0);
    chk("alu_prio_rdy", 64'(rs_must_1[2]), 64'd1);
    chk("alu_prio_val", 64'(write_data_1[31:0]), 64'hA5A5_A5A5);
    model_cycle();

    // flush with three buffered and a push attempt
    idle(); in1 = mk(30, 0, 1, 0, 1); in2 = mk(31, 0, 1, 0, 1); ren_valid_1 = 1; ren_valid_2 = 1;
    @(negedge clk); model_cycle();
    idle(); in1 = mk(32, 0, 1, 0, 1); ren_valid_1 = 1;
    @(negedge clk); model_cycle();
    idle(); flush = 1; in1 = mk(33, 0, 1, 0, 1); in2 = mk(34, 0, 1, 0, 1);
    ren_valid_1 = 1; ren_valid_2 = 1; free_1 = 1; free_2 = 1;
    @(negedge clk);
    chk("flush_wr", 64'(rs_write_dis), 64'd0);
    chk("flush_num", 64'(write_num_dis), 64'd0);
    chk("flush_head_rob", 64'(rs_must_1[20:15]), 64'd30);
    model_cycle();
    idle(); free_1 = 1; free_2 = 1;
    @(negedge clk);
    chk("post_flush_ready", 64'(ren_ready), 64'd1);
    chk("post_flush_wr", 64'(rs_write_dis), 64'd0);
    model_cycle();

    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      in1 = rnd_ent(); in2 = rnd_ent();
      ren_valid_1 = ($urandom_range(0, 9) < 7);
      ren_valid_2 = ren_valid_1 && ($urandom_range(0, 1) == 1);
      free_1 = 1'($urandom_range(0, 1));
      free_2 = free_1 && ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 19) == 0);
      rd_alu_wb = 6'($urandom_range(0, 9)); rd_sfu_wb = 6'($urandom_range(0, 9));
      rd_agu_wb = 6'($urandom_range(0, 9)); hit_wb_agu = 1'($urandom_range(0, 1));
      result_alu_wb = $urandom; result_sfu_wb = $urandom; result_agu_wb = $urandom;
      @(negedge clk);
      model_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
